// File: rtl/keypad_code_lock.sv
// Keypad code lock: collects digit keys, compares them on ENTER, then opens
// for a timed window, returns for a retry, or raises a timed alarm lockout.
module keypad_code_lock #(
   parameter int          CODE_LEN       = 4,
   parameter logic [31:0] CODE           = 32'h0000_1234,
   parameter int          MAX_TRIES      = 3,
   parameter int          OPEN_CYCLES    = 50_000_000,
   parameter int          LOCKOUT_CYCLES = 100_000_000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           key_valid,
   input  logic [3:0]                     key_code,
   output logic                           unlocked,
   output logic                           alarm,
   output logic [3:0]                     digit_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
   output logic [1:0]                     state
);
   // state    | meaning
   // ST_ENTRY | collecting digits, CLEAR/ENTER accepted
   // ST_CHECK | single-cycle compare of the collected entry
   // ST_OPEN  | unlocked, timer counting down, ENTER re-locks
   // ST_LOCK  | alarm lockout, timer counting down, all keys ignored
   typedef enum logic [1:0] {
      ST_ENTRY = 2'b00,
      ST_CHECK = 2'b01,
      ST_OPEN  = 2'b10,
      ST_LOCK  = 2'b11
   } state_t;

   localparam int EW    = CODE_LEN * 4;
   localparam int FW    = $clog2(MAX_TRIES + 1);
   localparam int T_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [EW-1:0] CODE_REF   = CODE[EW-1:0];
   localparam logic [3:0]    CODE_LEN_V = 4'(CODE_LEN);
   localparam logic [3:0]    KEY_CLEAR  = 4'hE;
   localparam logic [3:0]    KEY_ENTER  = 4'hF;

   state_t        st;
   logic [EW-1:0] entry;
   logic          overflow;
   logic [TW-1:0] timer;

   logic is_digit;
   logic key_clear;
   logic key_enter;
   logic match;
   logic last_try;

   assign state     = st;
   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign key_clear = key_valid && (key_code == KEY_CLEAR);
   assign key_enter = key_valid && (key_code == KEY_ENTER);
   assign match     = (digit_cnt == CODE_LEN_V) && !overflow && (entry == CODE_REF);
   assign last_try  = (({1'b0, fail_cnt}) + (FW+1)'(1)) == (FW+1)'(MAX_TRIES);

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_ENTRY;
         unlocked  <= 1'b0;
         alarm     <= 1'b0;
         digit_cnt <= '0;
         fail_cnt  <= '0;
         entry     <= '0;
         overflow  <= 1'b0;
         timer     <= '0;
      end else begin
         case (st)
            ST_ENTRY: begin
               if (is_digit) begin
                  // Extra digits beyond the code length poison the attempt.
                  if (digit_cnt < CODE_LEN_V) begin
                     entry     <= (entry << 4) | EW'(key_code);
                     digit_cnt <= digit_cnt + 4'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else if (key_clear) begin
                  digit_cnt <= '0;
                  entry     <= '0;
                  overflow  <= 1'b0;
               end else if (key_enter) begin
                  st <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               digit_cnt <= '0;
               entry     <= '0;
               overflow  <= 1'b0;
               if (match) begin
                  st       <= ST_OPEN;
                  unlocked <= 1'b1;
                  fail_cnt <= '0;
                  timer    <= TW'(OPEN_CYCLES - 1);
               end else if (last_try) begin
                  st       <= ST_LOCK;
                  alarm    <= 1'b1;
                  fail_cnt <= FW'(MAX_TRIES);
                  timer    <= TW'(LOCKOUT_CYCLES - 1);
               end else begin
                  st       <= ST_ENTRY;
                  fail_cnt <= fail_cnt + FW'(1);
               end
            end

            ST_OPEN: begin
               if (key_enter || (timer == '0)) begin
                  st       <= ST_ENTRY;
                  unlocked <= 1'b0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            ST_LOCK: begin
               if (timer == '0) begin
                  st       <= ST_ENTRY;
                  alarm    <= 1'b0;
                  fail_cnt <= '0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            default: st <= ST_ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: directed key sequences, a queue-based model of
// the lock checked every cycle, and literal expectations at key points.
module tb_keypad_code_lock;
   localparam int          LEN    = 4;
   localparam int          TRIES  = 3;
   localparam int          N_OPEN = 8;
   localparam int          N_LOCK = 16;
   localparam logic [31:0] CODE   = 32'h0000_1234;

   localparam int M_ENTRY = 0;
   localparam int M_CHECK = 1;
   localparam int M_OPEN  = 2;
   localparam int M_LOCK  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       unlocked;
   logic       alarm;
   logic [3:0] digit_cnt;
   logic [1:0] fail_cnt;
   logic [1:0] state;

   keypad_code_lock #(
      .CODE_LEN      (LEN),
      .CODE          (CODE),
      .MAX_TRIES     (TRIES),
      .OPEN_CYCLES   (N_OPEN),
      .LOCKOUT_CYCLES(N_LOCK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid),
      .key_code (key_code),
      .unlocked (unlocked),
      .alarm    (alarm),
      .digit_cnt(digit_cnt),
      .fail_cnt (fail_cnt),
      .state    (state)
   );

   always #50 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: digits held in a queue, time left in OPEN/LOCKOUT as a plain count.
   int m_mode  = M_ENTRY;
   int m_fails = 0;
   int m_left  = 0;
   int m_q[$];
   bit m_ovf   = 1'b0;
   bit m_match;

   function automatic int code_digit(input int i);
      return (CODE >> (4 * (LEN - 1 - i))) & 32'hF;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode  = M_ENTRY;
         m_fails = 0;
         m_left  = 0;
         m_ovf   = 1'b0;
         m_q.delete();
      end else begin
         case (m_mode)
            M_ENTRY: if (key_valid) begin
               if (key_code <= 4'd9) begin
                  if (m_q.size() < LEN) m_q.push_back(int'(key_code));
                  else m_ovf = 1'b1;
               end else if (key_code == 4'hE) begin
                  m_q.delete();
                  m_ovf = 1'b0;
               end else if (key_code == 4'hF) begin
                  m_mode = M_CHECK;
               end
            end
            M_CHECK: begin
               m_match = (m_q.size() == LEN) && !m_ovf;
               if (m_match)
                  for (int i = 0; i < LEN; i++)
                     if (m_q[i] != code_digit(i)) m_match = 1'b0;
               m_q.delete();
               m_ovf = 1'b0;
               if (m_match) begin
                  m_mode  = M_OPEN;
                  m_fails = 0;
                  m_left  = N_OPEN;
               end else if (m_fails + 1 == TRIES) begin
                  m_mode  = M_LOCK;
                  m_fails = TRIES;
                  m_left  = N_LOCK;
               end else begin
                  m_mode  = M_ENTRY;
                  m_fails = m_fails + 1;
               end
            end
            M_OPEN: begin
               m_left = m_left - 1;
               if ((key_valid && key_code == 4'hF) || m_left == 0) m_mode = M_ENTRY;
            end
            default: begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_mode  = M_ENTRY;
                  m_fails = 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_unlocked",  unlocked,  32'(m_mode == M_OPEN));
         check("cyc_alarm",     alarm,     32'(m_mode == M_LOCK));
         check("cyc_digit_cnt", digit_cnt, m_q.size());
         check("cyc_fail_cnt",  fail_cnt,  m_fails);
         check("cyc_state",     state,     m_mode);
      end
   end

   // Length of the most recent unlocked / alarm pulse, measured on the DUT.
   int run_u = 0, last_u = 0, run_a = 0, last_a = 0;
   always @(negedge clk) begin
      if (unlocked === 1'b1) run_u++;
      else begin
         if (run_u != 0) last_u = run_u;
         run_u = 0;
      end
      if (alarm === 1'b1) run_a++;
      else begin
         if (run_a != 0) last_a = run_a;
         run_a = 0;
      end
   end

   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic keys(input logic [63:0] seq, input int n);
      for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (state == 2'b00 && unlocked == 1'b0 && alarm == 1'b0) break;
      end
      @(negedge clk);
      check("reach_idle", state, 2'b00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset mid-entry, with keys strobed during reset
      keys(64'h12, 2);
      check("s1_pre_digits", digit_cnt, 2);
      rst = 1'b1; key_valid = 1'b1; key_code = 4'h3;
      @(negedge clk);
      key_code = 4'hF;
      @(negedge clk);
      rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;
      check("s1_digits", digit_cnt, 0);
      check("s1_state",  state,     0);
      check("s1_unlock", unlocked,  0);
      check("s1_alarm",  alarm,     0);
      check("s1_fail",   fail_cnt,  0);

      // Correct code
      keys(64'h123, 3);
      check("s2_digits3", digit_cnt, 3);
      press(4'h4);
      check("s2_digits4", digit_cnt, 4);
      press(4'hF);
      check("s2_check_state", state, 1);
      @(negedge clk);
      check("s2_unlocked", unlocked, 1);
      check("s2_fail", fail_cnt, 0);
      wait_idle();
      check("s2_open_len", last_u, 8);

      // Three wrong codes, lockout ignores keys, then unlock
      keys(64'h1235F, 5);
      check("s3_check_state", state, 1);
      @(negedge clk);
      check("s3_fail1", fail_cnt, 1);
      keys(64'h1235F, 5);
      @(negedge clk);
      check("s3_fail2", fail_cnt, 2);
      keys(64'h1235F, 5);
      @(negedge clk);
      check("s3_alarm", alarm, 1);
      check("s3_fail3", fail_cnt, 3);
      keys(64'h1234F, 5);
      check("s3_locked_unlocked", unlocked, 0);
      wait_idle();
      check("s3_lock_len", last_a, 16);
      check("s3_fail_clr", fail_cnt, 0);
      keys(64'h1234F, 5);
      @(negedge clk);
      check("s3_reopen", unlocked, 1);
      wait_idle();

      // Overflow and short entry, then CLEAR recovers
      keys(64'h12345F, 6);
      @(negedge clk);
      check("s4_ovf_fail", fail_cnt, 1);
      keys(64'h123F, 4);
      @(negedge clk);
      check("s4_short_fail", fail_cnt, 2);
      keys(64'h12E1234F, 8);
      @(negedge clk);
      check("s4_unlocked", unlocked, 1);
      check("s4_fail", fail_cnt, 0);
      wait_idle();

      // Ignored codes, then early relock on the 3rd OPEN cycle
      keys(64'h1A23D4F, 7);
      check("s5_check_state", state, 1);
      repeat (3) @(negedge clk);
      check("s5_open3", unlocked, 1);
      press(4'hF);
      check("s5_relock", unlocked, 0);
      check("s5_state", state, 0);

      // Reset on the 4th OPEN cycle
      keys(64'h1234F, 5);
      repeat (4) @(negedge clk);
      check("s6_open4", unlocked, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("s6_open_rst_unl", unlocked, 0);
      check("s6_open_rst_st",  state,    0);

      // Reset on the 5th LOCKOUT cycle
      for (int k = 0; k < 3; k++) begin
         keys(64'h9999F, 5);
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("s6_lock5", alarm, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("s6_lock_rst_alarm", alarm,    0);
      check("s6_lock_rst_fail",  fail_cnt, 0);
      check("s6_lock_rst_st",    state,    0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
